// File: rtl/alu_pkg.sv
// Shared definitions for the RV32 execute stage: op codes, FSM states and the
// helper that tells single-cycle ops from the iterative ones.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIVU = 4'd11;
  localparam logic [3:0] ALU_REMU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Decode/ALU register side (inputs plus stall) and ALU/MEM register side of
// the execute stage, bundled as one bus.
interface alu_exec_if #(parameter int XLEN = 32);

  logic            in_valid;
  logic [3:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic [4:0]      wb_addr_in;
  logic            wb_en_in;
  logic [2:0]      dc_ctrl_in;
  logic            stall;

  logic            out_valid;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] store_data;
  logic [4:0]      wb_addr_out;
  logic            wb_en_out;
  logic [2:0]      dc_ctrl_out;

  modport master (
    output in_valid, op, src1, src2, imm, use_imm, wb_addr_in, wb_en_in, dc_ctrl_in,
    input  stall, out_valid, result, store_data, wb_addr_out, wb_en_out, dc_ctrl_out
  );

  modport slave (
    input  in_valid, op, src1, src2, imm, use_imm, wb_addr_in, wb_en_in, dc_ctrl_in,
    output stall, out_valid, result, store_data, wb_addr_out, wb_en_out, dc_ctrl_out
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unit: shift-add multiply (low half) and restoring unsigned divide,
// one step per cycle for ITERS cycles after a start pulse.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITERS);

  logic [CW-1:0]   count;
  logic            running;
  logic [3:0]      op_q;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] bop;
  logic [XLEN:0]   rem_shift;
  logic            rem_ge;

  // For divide, acc is the partial remainder and quot shifts the dividend out
  // while the quotient bits shift in; for multiply, quot holds the multiplier.
  assign rem_shift = {acc, quot[XLEN-1]};
  assign rem_ge    = rem_shift >= {1'b0, bop};
  assign done      = running && (count == CW'(ITERS - 1));
  assign result    = (op_q == ALU_DIVU) ? quot : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      count   <= '0;
      op_q    <= ALU_ADD;
      acc     <= '0;
      quot    <= '0;
      bop     <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      op_q    <= op;
      acc     <= '0;
      quot    <= (op == ALU_MUL) ? b : a;
      bop     <= (op == ALU_MUL) ? a : b;
    end else if (running) begin
      count <= count + CW'(1);
      if (done) running <= 1'b0;
      if (op_q == ALU_MUL) begin
        if (quot[0]) acc <= acc + bop;
        bop  <= bop << 1;
        quot <= quot >> 1;
      end else if (rem_ge) begin
        acc  <= rem_shift[XLEN-1:0] - bop;
        quot <= {quot[XLEN-2:0], 1'b1};
      end else begin
        acc  <= rem_shift[XLEN-1:0];
        quot <= {quot[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// RV32 execute stage: single-cycle ALU plus an iterative MUL/DIVU/REMU unit,
// with registered result and sideband toward the ALU/MEM stage.
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int ITERS = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  bus
);

  state_t                 state;
  logic [XLEN-1:0]        opb;
  logic [4:0]             shamt;
  logic signed [XLEN-1:0] src1_s;
  logic [XLEN-1:0]        alu_res;
  logic                   mul_start;
  logic                   mul_done;
  logic [XLEN-1:0]        mul_res;

  assign opb    = bus.use_imm ? bus.imm : bus.src2;
  assign shamt  = opb[4:0];
  assign src1_s = bus.src1;

  always_comb begin
    alu_res = '0;
    case (bus.op)
      ALU_ADD:  alu_res = bus.src1 + opb;
      ALU_SUB:  alu_res = bus.src1 - opb;
      ALU_SLL:  alu_res = bus.src1 << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.src1) < $signed(opb))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.src1 < opb)};
      ALU_XOR:  alu_res = bus.src1 ^ opb;
      ALU_SRL:  alu_res = bus.src1 >> shamt;
      ALU_SRA:  alu_res = src1_s >>> shamt;
      ALU_OR:   alu_res = bus.src1 | opb;
      ALU_AND:  alu_res = bus.src1 & opb;
      default:  alu_res = '0;
    endcase
  end

  // Start only from IDLE, so the instruction held through DONE is never relaunched.
  assign mul_start = (state == ST_IDLE) && bus.in_valid && is_multi(bus.op);
  assign bus.stall = (state == ST_BUSY) || mul_start;

  alu_muldiv_iter #(.XLEN(XLEN), .ITERS(ITERS)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .op     (bus.op),
    .a      (bus.src1),
    .b      (opb),
    .done   (mul_done),
    .result (mul_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      bus.out_valid   <= 1'b0;
      bus.result      <= '0;
      bus.store_data  <= '0;
      bus.wb_addr_out <= '0;
      bus.wb_en_out   <= 1'b0;
      bus.dc_ctrl_out <= '0;
    end else begin
      bus.out_valid   <= 1'b0;
      bus.wb_en_out   <= 1'b0;
      bus.dc_ctrl_out <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && !is_multi(bus.op)) begin
            bus.out_valid   <= 1'b1;
            bus.result      <= alu_res;
            bus.store_data  <= bus.src2;
            bus.wb_addr_out <= bus.wb_addr_in;
            bus.wb_en_out   <= bus.wb_en_in;
            bus.dc_ctrl_out <= bus.dc_ctrl_in;
          end else if (mul_start) begin
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mul_done) state <= ST_DONE;
        end
        ST_DONE: begin
          bus.out_valid   <= 1'b1;
          bus.result      <= mul_res;
          bus.store_data  <= bus.src2;
          bus.wb_addr_out <= bus.wb_addr_in;
          bus.wb_en_out   <= bus.wb_en_in;
          bus.dc_ctrl_out <= bus.dc_ctrl_in;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed corner cases, an abort-by-reset case and random
// ops, all checked against a plain-arithmetic reference of the op set.
module tb_alu_exec;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_exec_if #(.XLEN(32)) bus ();

  alu_exec #(.XLEN(32), .ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] expRes;
  logic [31:0] expStore;
  logic [4:0]  expAddr;
  logic        expEn;
  logic [2:0]  expDc;
  logic        expMulti;

  function automatic logic [31:0] refModel(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] prod;
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return $signed(a) >>> sh;
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: begin
        prod = {32'd0, a} * {32'd0, b};
        return prod[31:0];
      end
      4'd11: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] immv, input logic useImm, input logic [4:0] addr,
                               input logic en, input logic [2:0] dc);
    bus.in_valid   = 1'b1;
    bus.op         = op;
    bus.src1       = a;
    bus.src2       = b;
    bus.imm        = immv;
    bus.use_imm    = useImm;
    bus.wb_addr_in = addr;
    bus.wb_en_in   = en;
    bus.dc_ctrl_in = dc;
    expRes   = refModel(op, a, useImm ? immv : b);
    expStore = b;
    expAddr  = addr;
    expEn    = en;
    expDc    = dc;
    expMulti = (op >= 4'd10) && (op <= 4'd12);
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    checkOutput({tag, "_result"}, bus.result, expRes);
    checkOutput({tag, "_store"}, bus.store_data, expStore);
    checkOutput({tag, "_wbaddr"}, {27'd0, bus.wb_addr_out}, {27'd0, expAddr});
    checkOutput({tag, "_wben"}, {31'd0, bus.wb_en_out}, {31'd0, expEn});
    checkOutput({tag, "_dc"}, {29'd0, bus.dc_ctrl_out}, {29'd0, expDc});
  endtask

  // Called at a negedge; leaves inputs held and returns at the negedge after
  // the result has been registered, so calls chain back to back.
  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] immv, input logic useImm,
                       input logic [4:0] addr, input logic en, input logic [2:0] dc);
    int stallCycles;
    applyStimulus(op, a, b, immv, useImm, addr, en, dc);
    #1;
    if (!expMulti) begin
      checkOutput({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
      @(negedge clk);
      checkResults(tag);
    end else begin
      stallCycles = 0;
      while (bus.stall && stallCycles < 100) begin
        stallCycles++;
        if (stallCycles > 1)
          checkOutput({tag, "_bubble"}, {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
      end
      checkOutput({tag, "_stallcycles"}, stallCycles, 32'd33);
      checkOutput({tag, "_donebubble"}, {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      checkResults(tag);
    end
  endtask

  task automatic idleCycle();
    bus.in_valid   = 1'b0;
    bus.op         = 4'($urandom_range(0, 15));
    bus.wb_en_in   = 1'b1;
    bus.dc_ctrl_in = 3'd7;
    #1;
    checkOutput("idle_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    checkOutput("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("idle_wben", {31'd0, bus.wb_en_out}, 32'd0);
    checkOutput("idle_dc", {29'd0, bus.dc_ctrl_out}, 32'd0);
  endtask

  initial begin
    logic sawValid;
    logic [3:0] rop;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.op         = 4'd0;
    bus.src1       = '0;
    bus.src2       = '0;
    bus.imm        = '0;
    bus.use_imm    = 1'b0;
    bus.wb_addr_in = '0;
    bus.wb_en_in   = 1'b0;
    bus.dc_ctrl_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_result", bus.result, 32'd0);
    checkOutput("rst_store", bus.store_data, 32'd0);
    checkOutput("rst_wbaddr", {27'd0, bus.wb_addr_out}, 32'd0);
    checkOutput("rst_wben", {31'd0, bus.wb_en_out}, 32'd0);
    checkOutput("rst_dc", {29'd0, bus.dc_ctrl_out}, 32'd0);
    checkOutput("rst_stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd1, 1'b1, 3'd0);
    checkOutput("add_wrap_const", bus.result, 32'h0);
    runOp("sub_wrap", 4'd1, 32'h0, 32'h1, 32'h0, 1'b0, 5'd2, 1'b1, 3'd1);
    checkOutput("sub_wrap_const", bus.result, 32'hFFFF_FFFF);
    runOp("sra_imm", 4'd7, 32'h8000_0000, 32'h1234_5678, 32'd4, 1'b1, 5'd3, 1'b1, 3'd2);
    checkOutput("sra_const", bus.result, 32'hF800_0000);
    runOp("srl_imm", 4'd6, 32'h8000_0000, 32'h1234_5678, 32'd4, 1'b1, 5'd4, 1'b0, 3'd3);
    checkOutput("srl_const", bus.result, 32'h0800_0000);
    runOp("slt", 4'd3, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd5, 1'b1, 3'd0);
    checkOutput("slt_const", bus.result, 32'd1);
    runOp("sltu", 4'd4, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd6, 1'b1, 3'd0);
    checkOutput("sltu_const", bus.result, 32'd0);
    runOp("op14", 4'd14, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 1'b0, 5'd7, 1'b1, 3'd5);
    idleCycle();

    runOp("mul_big", 4'd10, 32'h0001_0000, 32'h0001_0001, 32'h0, 1'b0, 5'd8, 1'b1, 3'd0);
    runOp("mul_zero", 4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 5'd9, 1'b1, 3'd0);
    checkOutput("mul_zero_const", bus.result, 32'h0);
    runOp("mul_7x6", 4'd10, 32'd7, 32'd6, 32'h0, 1'b0, 5'd10, 1'b1, 3'd0);
    checkOutput("mul_7x6_const", bus.result, 32'd42);
    runOp("divu", 4'd11, 32'd100, 32'd7, 32'h0, 1'b0, 5'd11, 1'b1, 3'd0);
    checkOutput("divu_const", bus.result, 32'd14);
    runOp("remu", 4'd12, 32'd100, 32'hFFFF_FFFF, 32'd7, 1'b1, 5'd12, 1'b1, 3'd0);
    checkOutput("remu_const", bus.result, 32'd2);
    runOp("divu_z", 4'd11, 32'd5, 32'd0, 32'h0, 1'b0, 5'd13, 1'b1, 3'd0);
    checkOutput("divu_z_const", bus.result, 32'hFFFF_FFFF);
    runOp("remu_z", 4'd12, 32'd5, 32'd0, 32'h0, 1'b0, 5'd14, 1'b1, 3'd0);
    checkOutput("remu_z_const", bus.result, 32'd5);
    idleCycle();

    runOp("seq_add1", 4'd0, 32'd10, 32'd20, 32'h0, 1'b0, 5'd3, 1'b1, 3'd0);
    runOp("seq_mul", 4'd10, 32'd123, 32'd456, 32'h0, 1'b0, 5'd9, 1'b1, 3'd0);
    runOp("seq_add2", 4'd0, 32'd1, 32'd2, 32'h0, 1'b0, 5'd17, 1'b1, 3'd0);
    checkOutput("seq_add2_addr", {27'd0, bus.wb_addr_out}, 32'd17);
    idleCycle();

    runOp("pre_abort", 4'd0, 32'd5, 32'd6, 32'h0, 1'b0, 5'd12, 1'b1, 3'd3);
    applyStimulus(4'd10, 32'd9, 32'd9, 32'h0, 1'b0, 5'd21, 1'b1, 3'd1);
    repeat (11) @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("abort_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("abort_result", bus.result, 32'd0);
    checkOutput("abort_store", bus.store_data, 32'd0);
    checkOutput("abort_wbaddr", {27'd0, bus.wb_addr_out}, 32'd0);
    checkOutput("abort_wben", {31'd0, bus.wb_en_out}, 32'd0);
    checkOutput("abort_dc", {29'd0, bus.dc_ctrl_out}, 32'd0);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sawValid = sawValid | bus.out_valid;
    end
    checkOutput("abort_never_valid", {31'd0, sawValid}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) idleCycle();
      rop = 4'($urandom_range(0, 15));
      runOp("rand", rop, $urandom(), ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom(),
            $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    idleCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
